mux8way16_arbiter: RTL

- Shares one 16-bit output channel among eight requesters (a..h) with a round-robin arbiter.
- Drives the 3-bit select of an internal mux8way16 instance and presents the selected word on a valid/ready output handshake.
- Each requester holds the channel for a burst of beats; the burst ends on a `last` flag or when the burst limit is reached.
- Sits between eight word sources and a single consumer, such as a memory write port or an output bus.

---
 rtl/mux8way16_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mux8way16_arbiter.sv
// mux8way16_arbiter: round-robin arbiter sharing one 16-bit valid/ready channel among eight sources
//
// Ports:
//   clock_i        rising-edge clock
//   reset_i        asynchronous active-high reset
//   req_i[7:0]     per-source request (bit0 = a ... bit7 = h)
//   last_i[7:0]    per-source end-of-burst flag, honoured only on a transfer by the owner
//   a_i..h_i       16-bit source words
//   out_ready_i    consumer accepts the presented beat
//   out_o          selected word, zero whenever out_valid_o is low
//   out_valid_o    a beat is presented (owner still requesting)
//   grant_o[7:0]   one-hot owner, zero when idle
//   sel_o[2:0]     registered mux select, index of the grant bit
//   busy_o         high while a grant is held
//
// Build option: define MUX8WAY16_ARBITER_FIXED_PRIORITY_EN to replace the
// round-robin search with fixed priority (a highest, h lowest).

// mux8way16: plain 8-to-1 word multiplexer
module mux8way16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [15:0] c_i,
    input  logic [15:0] d_i,
    input  logic [15:0] e_i,
    input  logic [15:0] f_i,
    input  logic [15:0] g_i,
    input  logic [15:0] h_i,
    input  logic [2:0]  sel_i,
    output logic [15:0] out_o
);
    always_comb begin
        out_o = sel_i[2] ? (sel_i[1] ? (sel_i[0] ? h_i : g_i) : (sel_i[0] ? f_i : e_i))
                         : (sel_i[1] ? (sel_i[0] ? d_i : c_i) : (sel_i[0] ? b_i : a_i));
    end
endmodule

module mux8way16_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  req_i,
    input  logic [7:0]  last_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic [15:0] c_i,
    input  logic [15:0] d_i,
    input  logic [15:0] e_i,
    input  logic [15:0] f_i,
    input  logic [15:0] g_i,
    input  logic [15:0] h_i,
    input  logic        out_ready_i,
    output logic [15:0] out_o,
    output logic        out_valid_o,
    output logic [7:0]  grant_o,
    output logic [2:0]  sel_o,
    output logic        busy_o
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [7:0]  grant_q, grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  pick;
    logic [15:0] mux_out;
    logic        xfer;
    logic        rel;

    mux8way16 u_mux (
        .a_i   (a_i),
        .b_i   (b_i),
        .c_i   (c_i),
        .d_i   (d_i),
        .e_i   (e_i),
        .f_i   (f_i),
        .g_i   (g_i),
        .h_i   (h_i),
        .sel_i (sel_q),
        .out_o (mux_out)
    );

`ifdef MUX8WAY16_ARBITER_FIXED_PRIORITY_EN
    // Scan from h down to a so the lowest requesting index wins.
    always_comb begin
        pick = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (req_i[k]) pick = 3'(k);
        end
    end
`else
    // Scan from ptr+8 (= ptr) down to ptr+1 so the nearest requester after
    // the previous owner wins; the previous owner itself is tried last.
    always_comb begin
        pick = ptr_q;
        for (int k = 8; k >= 1; k--) begin
            if (req_i[ptr_q + 3'(k)]) pick = ptr_q + 3'(k);
        end
    end
`endif

    always_comb begin
        busy_o      = (state_q == GRANT);
        out_valid_o = busy_o & req_i[sel_q];
        out_o       = out_valid_o ? mux_out : 16'h0000;
        grant_o     = grant_q;
        sel_o       = sel_q;
        xfer        = out_valid_o & out_ready_i;
        // Dropping the request ends the burst even without a transfer.
        rel         = busy_o & (~req_i[sel_q] | (xfer & (last_i[sel_q] | (cnt_q == LAST_BEAT))));
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (|req_i) begin
                state_d = GRANT;
                sel_d   = pick;
                grant_d = 8'd1 << pick;
                cnt_d   = 8'd0;
            end
        end else begin
            if (xfer) cnt_d = cnt_q + 8'd1;
            if (rel) begin
                state_d = IDLE;
                grant_d = 8'd0;
`ifndef MUX8WAY16_ARBITER_FIXED_PRIORITY_EN
                ptr_d   = sel_q;
`endif
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd7;
            grant_q <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    a_grant_onehot: assert property (@(posedge clock_i) disable iff (reset_i)
        $onehot0(grant_q));
    a_grant_matches_sel: assert property (@(posedge clock_i) disable iff (reset_i)
        busy_o |-> (grant_q == (8'd1 << sel_q)));
    a_idle_no_grant: assert property (@(posedge clock_i) disable iff (reset_i)
        !busy_o |-> (grant_q == 8'd0));
    a_out_zero_when_invalid: assert property (@(posedge clock_i) disable iff (reset_i)
        !out_valid_o |-> (out_o == 16'h0000));
    a_sel_stable_in_grant: assert property (@(posedge clock_i) disable iff (reset_i)
        (busy_o && !rel) |=> (sel_q == $past(sel_q)));
endmodule
